// File: rtl/alu_exec_iter.sv
// alu_exec_iter: iterative RV32I execute unit.
// Logic and arithmetic ops finish one cycle after acceptance. Shifts run
// serially, one bit position per cycle, in the result register. Requests and
// results each pass through a valid/ready handshake.
module alu_exec_iter #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [3:0]      i_alu_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_res_valid,
  input  logic            i_res_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_illegal,
  output logic            o_busy
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SLT  = 4'd2,
    OP_SLTU = 4'd3,
    OP_XOR  = 4'd4,
    OP_OR   = 4'd5,
    OP_AND  = 4'd6,
    OP_SLL  = 4'd7,
    OP_SRL  = 4'd8,
    OP_SRA  = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      op_q, op_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic            illegal_q, illegal_d;

  logic [SHW-1:0]  shamt;
  logic            accept;

  // Single-cycle ops. Compares return a zero-extended 0/1; add/sub wrap.
  function automatic logic [XLEN-1:0] alu_comb(input logic [3:0]      op,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] a_s;
    logic signed [XLEN-1:0] b_s;
    logic [XLEN-1:0]        r;
    a_s = a;
    b_s = b;
    r   = '0;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_SLT:  r = {{(XLEN-1){1'b0}}, (a_s < b_s)};
      OP_SLTU: r = {{(XLEN-1){1'b0}}, (a < b)};
      OP_XOR:  r = a ^ b;
      OP_OR:   r = a | b;
      OP_AND:  r = a & b;
      default: r = '0;
    endcase
    return r;
  endfunction

  // One bit position of a serial shift: SLL fills 0 at the LSB, SRL fills 0
  // at the MSB, SRA replicates the sign bit.
  function automatic logic [XLEN-1:0] shift_step(input logic [3:0]      op,
                                                 input logic [XLEN-1:0] v);
    logic signed [XLEN-1:0] v_s;
    logic [XLEN-1:0]        r;
    v_s = v;
    case (op)
      OP_SLL:  r = {v[XLEN-2:0], 1'b0};
      OP_SRL:  r = {1'b0, v[XLEN-1:1]};
      OP_SRA:  r = v_s >>> 1;
      default: r = v;
    endcase
    return r;
  endfunction

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

  function automatic logic is_legal(input logic [3:0] op);
    return op <= OP_SRA;
  endfunction

  assign shamt  = i_b[SHW-1:0];
  assign accept = i_valid && (state_q == ST_IDLE) && !i_flush;

  // Next-state and datapath update; flush overrides everything and clears the counter.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    illegal_d = illegal_q;
    if (i_flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_d = i_alu_op;
            if (!is_legal(i_alu_op)) begin
              result_d  = '0;
              illegal_d = 1'b1;
              state_d   = ST_DONE;
            end else if (is_shift(i_alu_op)) begin
              illegal_d = 1'b0;
              result_d  = i_a;
              if (shamt == '0) begin
                state_d = ST_DONE;
              end else begin
                cnt_d   = shamt;
                state_d = ST_SHIFT;
              end
            end else begin
              illegal_d = 1'b0;
              result_d  = alu_comb(i_alu_op, i_a, i_b);
              state_d   = ST_DONE;
            end
          end
        end
        ST_SHIFT: begin
          result_d = shift_step(op_q, result_q);
          cnt_d    = cnt_q - SHW'(1);
          if (cnt_q == SHW'(1)) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          if (i_res_ready) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, operands and result registers; reset discards any operation in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

  assign o_ready     = (state_q == ST_IDLE);
  assign o_busy      = (state_q != ST_IDLE);
  assign o_res_valid = (state_q == ST_DONE);
  assign o_result    = result_q;
  assign o_illegal   = illegal_q;

endmodule
